// File: rtl/ex_mem_arbiter.sv
// Dual-lane EX/MEM pipeline register. Pairs of memory ops that touch the same word
// and include a store are split over two cycles, lane 1 first.
module ex_mem_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallM,
    input  logic             ValidE1,
    input  logic             ValidE2,
    input  logic             MemReqE1,
    input  logic             MemReqE2,
    input  logic             MemWriteE1,
    input  logic             MemWriteE2,
    input  logic [2:0]       AddressingControlE1,
    input  logic [2:0]       AddressingControlE2,
    input  logic [31:0]      ALUResultE1,
    input  logic [31:0]      ALUResultE2,
    input  logic [31:0]      WriteDataE1,
    input  logic [31:0]      WriteDataE2,
    input  logic [4:0]       RdE1,
    input  logic [4:0]       RdE2,
    input  logic             RegWriteE1,
    input  logic             RegWriteE2,
    output logic             StallE,
    output logic             ValidM1,
    output logic             ValidM2,
    output logic             MemWriteM1,
    output logic             MemWriteM2,
    output logic [2:0]       AddressingControlM1,
    output logic [2:0]       AddressingControlM2,
    output logic [31:0]      ALUResultM1,
    output logic [31:0]      ALUResultM2,
    output logic [31:0]      WriteDataM1,
    output logic [31:0]      WriteDataM2,
    output logic [4:0]       RdM1,
    output logic [4:0]       RdM2,
    output logic             RegWriteM1,
    output logic             RegWriteM2,
    output logic [CNT_W-1:0] SplitCount,
    output logic             dbg_state
);

    typedef enum logic {
        PASS  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    typedef struct packed {
        logic        valid;
        logic        mem_write;
        logic [2:0]  ac;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        reg_write;
    } slot_t;

    // An invalid lane becomes an all-zero bubble.
    function automatic slot_t make_slot(input logic valid, input logic mem_req,
                                        input logic mem_write, input logic [2:0] ac,
                                        input logic [31:0] alu, input logic [31:0] wd,
                                        input logic [4:0] rd, input logic reg_write);
        slot_t s;
        s = '0;
        if (valid) begin
            s.valid     = 1'b1;
            s.mem_write = mem_write & mem_req;
            s.ac        = ac;
            s.alu       = alu;
            s.wd        = wd;
            s.rd        = rd;
            s.reg_write = reg_write;
        end
        return s;
    endfunction

    state_t           state;
    slot_t            m1, m2;
    slot_t            lane1, lane2;
    logic             conflict;
    logic [CNT_W-1:0] cnt_one;

    assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    assign lane1 = make_slot(ValidE1, MemReqE1, MemWriteE1, AddressingControlE1,
                             ALUResultE1, WriteDataE1, RdE1, RegWriteE1);
    assign lane2 = make_slot(ValidE2, MemReqE2, MemWriteE2, AddressingControlE2,
                             ALUResultE2, WriteDataE2, RdE2, RegWriteE2);

    // Word-granular and conservative: any byte overlap within a word counts.
    assign conflict = ValidE1 & ValidE2 & MemReqE1 & MemReqE2 &
                      (ALUResultE1[31:2] == ALUResultE2[31:2]) &
                      (MemWriteE1 | MemWriteE2);

    // Handshake: while StallE is high the upstream stage holds ValidE* and all lane
    // fields unchanged; the pair is consumed on the first rising edge with StallE low,
    // or over two edges (PASS then SPLIT) when the pair conflicts.
    assign StallE = StallM | ((state == PASS) & conflict);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PASS;
            m1         <= '0;
            m2         <= '0;
            SplitCount <= '0;
        end else if (!StallM) begin
            case (state)
                PASS: begin
                    if (conflict) begin
                        m1    <= lane1;
                        m2    <= '0;
                        state <= SPLIT;
                        if (SplitCount != '1)
                            SplitCount <= SplitCount + cnt_one;
                    end else begin
                        m1    <= lane1;
                        m2    <= lane2;
                        state <= PASS;
                    end
                end
                SPLIT: begin
                    m1    <= '0;
                    m2    <= lane2;
                    state <= PASS;
                end
                default: state <= PASS;
            endcase
        end
    end

    assign ValidM1             = m1.valid;
    assign MemWriteM1          = m1.mem_write;
    assign AddressingControlM1 = m1.ac;
    assign ALUResultM1         = m1.alu;
    assign WriteDataM1         = m1.wd;
    assign RdM1                = m1.rd;
    assign RegWriteM1          = m1.reg_write;

    assign ValidM2             = m2.valid;
    assign MemWriteM2          = m2.mem_write;
    assign AddressingControlM2 = m2.ac;
    assign ALUResultM2         = m2.alu;
    assign WriteDataM2         = m2.wd;
    assign RdM2                = m2.rd;
    assign RegWriteM2          = m2.reg_write;

    assign dbg_state = (state == SPLIT);

endmodule
